// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters.
// A one-entry response stage routes each access's completion back to its port.

module sram_rr_rsp_lane #(
  parameter int unsigned Width = 32
) (
  input  logic             hit_i,
  input  logic             write_i,
  input  logic [Width-1:0] sram_rdata_i,
  output logic             rsp_valid_o,
  output logic [Width-1:0] rsp_rdata_o
);
  assign rsp_valid_o = hit_i;
  // Write completions carry no data; keep idle lanes quiet too.
  assign rsp_rdata_o = (hit_i && !write_i) ? sram_rdata_i : '0;
endmodule

module sram_rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Width  = 32,
  parameter int unsigned Depth  = 1 << 15,
  parameter int unsigned Aw     = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq-1:0]            req_write_i,
  input  logic [NumReq-1:0][Aw-1:0]    req_addr_i,
  input  logic [NumReq-1:0][Width-1:0] req_wdata_i,
  input  logic [NumReq-1:0][Width-1:0] req_wmask_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  output logic [NumReq-1:0][Width-1:0] rsp_rdata_o,
  output logic                         sram_req_o,
  output logic                         sram_write_o,
  output logic [Aw-1:0]                sram_addr_o,
  output logic [Width-1:0]             sram_wdata_o,
  output logic [Width-1:0]             sram_wmask_o,
  input  logic [Width-1:0]             sram_rdata_i
);
  localparam int unsigned Pw = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef struct packed {
    logic          vld;
    logic [Pw-1:0] port;
    logic          write;
  } rsp_t;

  logic [Pw-1:0] ptr_q, ptr_d;
  logic [Pw-1:0] gnt_idx;
  logic          gnt_any;
  logic [Pw:0]   scan;
  logic          acc;
  rsp_t          rsp_q, rsp_d;

  // Scan upward from the pointer with wrap; first valid port wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      scan = {1'b0, ptr_q} + (Pw+1)'(k);
      if (scan >= (Pw+1)'(NumReq)) scan = scan - (Pw+1)'(NumReq);
      if (!gnt_any && req_valid_i[scan[Pw-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[Pw-1:0];
      end
    end
  end

  // Outputs are forced quiet while reset is held, whatever the requesters do.
  assign acc        = rst_ni & gnt_any;
  assign sram_req_o = rst_ni & (|req_valid_i);

  always_comb begin
    req_ready_o = '0;
    if (acc) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    sram_write_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (acc) begin
      sram_write_o = req_write_i[gnt_idx];
      sram_addr_o  = req_addr_i[gnt_idx];
      sram_wdata_o = req_wdata_i[gnt_idx];
      sram_wmask_o = req_wmask_i[gnt_idx];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = (gnt_idx == Pw'(NumReq - 1)) ? '0 : gnt_idx + Pw'(1);
  end

  always_comb begin
    rsp_d = '0;
    if (acc) begin
      rsp_d.vld   = 1'b1;
      rsp_d.port  = gnt_idx;
      rsp_d.write = req_write_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      rsp_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_q <= rsp_d;
    end
  end

  for (genvar p = 0; p < int'(NumReq); p++) begin : g_lane
    sram_rr_rsp_lane #(.Width(Width)) u_lane (
      .hit_i       (rsp_q.vld && (rsp_q.port == Pw'(p))),
      .write_i     (rsp_q.write),
      .sram_rdata_i(sram_rdata_i),
      .rsp_valid_o (rsp_valid_o[p]),
      .rsp_rdata_o (rsp_rdata_o[p])
    );
  end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 Parameters SHALL be: NumReq, default 2, number of requester ports (2..8); Width, default 32, data bits; Depth, default 1<<15, SRAM words; Aw, derived $clog2(Depth), address bits.
REQ-002 clk_i  in  1  single clock; all state on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  in  NumReq  per-port request valid.
REQ-005 req_ready_o  out  NumReq  per-port request accepted this cycle.
REQ-006 req_write_i  in  NumReq  per-port 1=write, 0=read.
REQ-007 req_addr_i  in  NumReq*Aw  per-port word address.
REQ-008 req_wdata_i  in  NumReq*Width  per-port write data.
REQ-009 req_wmask_i  in  NumReq*Width  per-port bit-granular write mask.
REQ-010 rsp_valid_o  out  NumReq  per-port response pulse.
REQ-011 rsp_rdata_o  out  NumReq*Width  per-port read data, qualified by rsp_valid_o.
REQ-012 sram_req_o  out  1  SRAM access strobe.
REQ-013 sram_write_o  out  1  SRAM write enable.
REQ-014 sram_addr_o  out  Aw  SRAM word address.
REQ-015 sram_wdata_o  out  Width  SRAM write data.
REQ-016 sram_wmask_o  out  Width  SRAM write mask.
REQ-017 sram_rdata_i  in  Width  SRAM read data, valid one cycle after a read strobe.

Function
REQ-018 Arbitration SHALL be combinational round-robin: the granted port is the first asserted req_valid_i at or after the priority pointer, scanning upward with wrap from NumReq-1 to 0.
REQ-019 At most one req_ready_o bit SHALL be high per cycle, only for a port with req_valid_i high; an accepted transfer is req_valid_i & req_ready_o.
REQ-020 sram_req_o SHALL equal OR of req_valid_i; sram_write_o/addr/wdata/wmask SHALL be the granted port's fields, all zero when no port is valid.
REQ-021 On an accepted transfer the priority pointer SHALL advance to (granted+1) mod NumReq; with no transfer it SHALL hold.
REQ-022 A single continuously valid port SHALL be granted every cycle (no idle bubbles).
REQ-023 A 1-entry response pipeline SHALL register {valid, port index, write} of each accepted transfer.
REQ-024 In the cycle after an accepted transfer, rsp_valid_o[port] SHALL pulse high for exactly one cycle, for both reads and writes.
REQ-025 For a read response, rsp_rdata_o of that port SHALL equal sram_rdata_i; for a write response, and for every port without a response, rsp_rdata_o SHALL be zero.
REQ-026 Responses SHALL NOT be back-pressured; back-to-back accepted transfers SHALL yield back-to-back responses in grant order, one per cycle.
REQ-027 A port whose request is not granted SHALL keep its fields stable with req_valid_i high until granted; the arbiter SHALL NOT drop or reorder a held request.
REQ-028 Starvation bound: any continuously valid port SHALL be granted within NumReq cycles.
REQ-029 Address, data and mask SHALL pass unmodified (no relocation, no width conversion).

Reset
REQ-030 While rst_ni is low: priority pointer = 0, response pipeline valid = 0, rsp_valid_o = 0, rsp_rdata_o = 0; req_ready_o and sram_* outputs SHALL be zero regardless of req_valid_i.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight response (no rsp_valid_o pulse after reset release for pre-reset grants).
REQ-032 First cycle after reset release SHALL arbitrate from port 0.

Verification
REQ-033 NumReq=2, only port 0 reads addr 0x10 (mem=0xDEADBEEF) -> ready[0]=1 same cycle, next cycle rsp_valid_o=2'b01, rsp_rdata_o[0]=0xDEADBEEF.
REQ-034 Ports 0 and 1 continuously valid for 4 cycles after reset -> grants 0,1,0,1; responses 0,1,0,1 each one cycle later.
REQ-035 Port 1 writes 0xA5A5A5A5 mask 0x0000FFFF to addr 3 (old 0x12345678), then port 0 reads addr 3 -> write rsp with rdata 0, read rsp rdata 0x1234A5A5.
REQ-036 NumReq=4, ports 1 and 3 valid, pointer=2 -> grant 3, pointer becomes 0, next grant 1.
REQ-037 Assert rst_ni low the cycle after port 0 read grant -> rsp_valid_o stays 0, pointer 0 after release, outputs zero during reset.
REQ-038 No port valid for 10 cycles -> sram_req_o=0, pointer unchanged, no rsp_valid_o pulses.
